// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the frame-sequencer state encoding and the 8N1 frame constants so a
// companion receiver can decode the same frame format from one place.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int   DATA_BITS  = 8;
  localparam int   STOP_BITS  = 1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter, 8N1 framing (start, 8 data bits LSB first, stop).
//
// Ports:
//   sysclk       in   system clock, all logic on its rising edge
//   reset        in   synchronous active-high reset, aborts any frame in flight
//   i_Tx_start   in   one-cycle request to send i_Tx_Byte (ignored while active)
//   i_Tx_Byte    in   byte to send, latched only when a start is accepted
//   o_Tx_Serial  out  serial line, idles high
//   o_Tx_Active  out  high from the start bit through the end of the stop bit
//   o_Tx_Done    out  one-cycle pulse as the stop bit ends
//   o_dbg_state  out  current sequencer state (uart_pkg::state_t encoding)
//
// Handshake: a start is taken on any rising edge where i_Tx_start=1 and
// o_Tx_Active=0 (IDLE or DONE). Starts while o_Tx_Active=1 are dropped, not
// queued. o_Tx_Active rises the cycle after the accepted start and o_Tx_Done
// pulses for exactly one cycle with o_Tx_Active already low.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       i_Tx_start,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done,
  output logic [2:0] o_dbg_state
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

  state_t            state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        data_q;
  logic              serial_q;
  logic              active_q;
  logic              done_q;

  logic [BAUD_W-1:0] baud_d;
  logic [2:0]        bit_idx_d;
  logic              bit_end;

  assign baud_d    = baud_q + 1'b1;
  assign bit_idx_d = bit_idx_q + 3'd1;
  // Last cycle of the current bit period; the next edge moves to the next bit.
  assign bit_end   = (baud_q == BAUD_LAST);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      serial_q  <= IDLE_LEVEL;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // DONE behaves like IDLE for acceptance so a controller restarting on
        // the falling edge of o_Tx_Active gets no extra idle gap.
        IDLE, DONE: begin
          if (i_Tx_start) begin
            data_q    <= i_Tx_Byte;
            active_q  <= 1'b1;
            serial_q  <= 1'b0;
            baud_q    <= '0;
            bit_idx_q <= '0;
            state_q   <= START;
          end else begin
            serial_q <= IDLE_LEVEL;
            state_q  <= IDLE;
          end
        end
        START: begin
          if (bit_end) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            serial_q  <= data_q[0];
            state_q   <= DATA;
          end else begin
            baud_q <= baud_d;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_q    <= '0;
            // Index wraps 7->0 on the way out, ready for the next frame.
            bit_idx_q <= bit_idx_d;
            if (bit_idx_q == BIT_LAST) begin
              serial_q <= IDLE_LEVEL;
              state_q  <= STOP;
            end else begin
              serial_q <= data_q[bit_idx_d];
            end
          end else begin
            baud_q <= baud_d;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_q   <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            baud_q <= baud_d;
          end
        end
        default: begin
          serial_q <= IDLE_LEVEL;
          active_q <= 1'b0;
          baud_q   <= '0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign o_Tx_Serial = serial_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Done   = done_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT=4. Inputs change on the falling
// edge, outputs are sampled on the falling edge. "Cycle n" means the falling
// edge right after rising edge E0+n, where E0 is the edge accepting a start.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int FRAME_CYC = 10 * CPB;

  logic       clk;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_serial;
  logic       tx_active;
  logic       tx_done;
  logic [2:0] dbg_state;

  int n_cmp;
  int n_err;
  int done_cnt;

  logic [0:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;  // bit i = level of the i-th bit period on the wire
    string      name;
  } vec_t;

  vec_t vecs[5];

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .sysclk      (clk),
    .reset       (rst),
    .i_Tx_start  (tx_start),
    .i_Tx_Byte   (tx_byte),
    .o_Tx_Serial (tx_serial),
    .o_Tx_Active (tx_active),
    .o_Tx_Done   (tx_done),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time exceeded, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (!rst) begin
      n_cmp++;
      if (tx_done && tx_active) begin
        n_err++;
        $display("FAIL done_active_overlap: got done=1 active=1, required not both");
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Pulse start with byte d; returns at cycle 0 of the frame.
  task automatic start_frame(input logic [7:0] d);
    @(negedge clk);
    tx_start = 1'b1;
    tx_byte  = d;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Called at cycle 0; returns at cycle 40 (done cycle) after checking it.
  // busy_at / chg_at: edge offsets for a stray start / byte change (-1 = none).
  task automatic check_frame(input logic [9:0] line, input string name,
                             input int busy_at, input logic [7:0] busy_byte,
                             input int chg_at, input logic [7:0] chg_byte);
    logic [0:0] e;
    for (int b = 0; b < 10; b++)
      for (int c = 0; c < CPB; c++) exp_q.push_back(line[b]);
    for (int n = 0; n < FRAME_CYC; n++) begin
      e = exp_q.pop_front();
      check($sformatf("%s serial c%0d", name, n), 32'(tx_serial), 32'(e));
      check($sformatf("%s active c%0d", name, n), 32'(tx_active), 32'd1);
      tx_start = 1'b0;
      if (n + 1 == busy_at) begin
        tx_start = 1'b1;
        tx_byte  = busy_byte;
      end
      if (n + 1 == chg_at) tx_byte = chg_byte;
      @(negedge clk);
    end
    tx_start = 1'b0;
    check({name, " done pulse"},  32'(tx_done),   32'd1);
    check({name, " active@done"}, 32'(tx_active), 32'd0);
    check({name, " serial@done"}, 32'(tx_serial), 32'd1);
  endtask

  task automatic check_idle(input string name);
    check({name, " idle done"},   32'(tx_done),   32'd0);
    check({name, " idle active"}, 32'(tx_active), 32'd0);
    check({name, " idle serial"}, 32'(tx_serial), 32'd1);
  endtask

  // ---------------- test ----------------
  initial begin
    int d0;
    n_cmp    = 0;
    n_err    = 0;
    done_cnt = 0;
    rst      = 1'b1;
    tx_start = 1'b0;
    tx_byte  = 8'h00;

    vecs[0] = '{8'h41, 10'h282, "A_41"};
    vecs[1] = '{8'h00, 10'h200, "x00"};
    vecs[2] = '{8'hFF, 10'h3FE, "xFF"};
    vecs[3] = '{8'hA5, 10'h34A, "xA5"};
    vecs[4] = '{8'h80, 10'h300, "x80"};

    // Reset held 3 cycles, then idle levels held.
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle($sformatf("post_reset%0d", i));
    end
    check("reset dbg_state", 32'(dbg_state), 32'd0);

    // Table-driven frames.
    for (int i = 0; i < 5; i++) begin
      d0 = done_cnt;
      start_frame(vecs[i].data);
      check_frame(vecs[i].line, vecs[i].name, -1, 8'h00, -1, 8'h00);
      @(negedge clk);
      check_idle(vecs[i].name);
      check({vecs[i].name, " done count"}, 32'(done_cnt - d0), 32'd1);
    end

    // Busy start: 0xFF requested at E0+12 while 0x00 is on the line.
    d0 = done_cnt;
    start_frame(8'h00);
    check_frame(10'h200, "busy", 12, 8'hFF, -1, 8'h00);
    for (int i = 0; i < 2 * FRAME_CYC; i++) @(negedge clk);
    check_idle("busy after");
    check("busy done count", 32'(done_cnt - d0), 32'd1);

    // Byte stability: byte changes 0x55 -> 0xAA at E0+1.
    start_frame(8'h55);
    check_frame(10'h2AA, "stable", -1, 8'h00, 1, 8'hAA);
    @(negedge clk);

    // Back-to-back: controller restarts when it sees active low (done cycle).
    d0 = done_cnt;
    start_frame(8'h0D);
    check_frame(10'h21A, "b2b_0D", -1, 8'h00, -1, 8'h00);
    // Stop bit already high 4 cycles; this done cycle is the 5th.
    tx_start = 1'b1;
    tx_byte  = 8'h30;
    @(negedge clk);
    tx_start = 1'b0;
    check("b2b restart active", 32'(tx_active), 32'd1);
    check_frame(10'h260, "b2b_30", -1, 8'h00, -1, 8'h00);
    @(negedge clk);
    check_idle("b2b after");
    check("b2b done count", 32'(done_cnt - d0), 32'd2);

    // Reset mid-frame at E0+17.
    d0 = done_cnt;
    start_frame(8'h00);
    for (int n = 0; n < 16; n++) @(negedge clk);
    check("midrst pre serial", 32'(tx_serial), 32'd0);
    check("midrst pre active", 32'(tx_active), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst serial", 32'(tx_serial), 32'd1);
    check("midrst active", 32'(tx_active), 32'd0);
    check("midrst done",   32'(tx_done),   32'd0);
    rst = 1'b0;
    for (int i = 0; i < 2 * FRAME_CYC; i++) @(negedge clk);
    check_idle("midrst idle");
    check("midrst no done", 32'(done_cnt - d0), 32'd0);
    start_frame(8'h31);
    check_frame(10'h262, "after_rst_31", -1, 8'h00, -1, 8'h00);
    @(negedge clk);

    // Reset together with start: reset wins.
    tx_start = 1'b1;
    tx_byte  = 8'h41;
    rst      = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    rst      = 1'b0;
    check_idle("rst_vs_start");
    @(negedge clk);
    check_idle("rst_vs_start+1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
